atm_keypad_entry: RTL
=====================

Name: atm_keypad_entry

Overview:
Keypad front-end for the ATM controller. It debounces raw key presses and produces a one-cycle strobe per accepted key. In PIN mode it forwards single digits (DIGITO/DIGITO_STB). In amount mode it accumulates decimal digits into a 32-bit MONTO and strobes it on ENTER (MONTO/MONTO_STB). Its outputs connect directly to the matching inputs of the ATM transaction FSM.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles needed to accept a press, and likewise a release (must be >= 2).
MAX_DIGITS, 9, maximum amount digits; 9 keeps 999999999 below 2^32.
CNT_W, 5, width of the debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset
TECLA_VALIDA  in  1  raw key-down level from keypad scanner, may bounce
TECLA  in  4  raw key code: 0-9 digit, 4'hA ENTER, 4'hB BORRAR, 4'hC CANCELAR, others invalid
MODO  in  1  0 = PIN entry, 1 = amount entry (driven by the transaction FSM)
DIGITO  out  4  last accepted digit (PIN mode)
DIGITO_STB  out  1  one-cycle pulse, DIGITO valid
MONTO  out  32  committed amount, binary
MONTO_STB  out  1  one-cycle pulse, MONTO valid
CANCELAR_STB  out  1  one-cycle pulse on accepted CANCELAR
ERROR_ENTRADA  out  1  one-cycle pulse on a rejected key
DIGITOS_ACUM  out  4  number of digits currently held in the amount accumulator

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE, counter 0, accumulator 0, all outputs 0. Leaving reset is synchronous to CLK.
- Key FSM states:
  - IDLE: on TECLA_VALIDA=1, latch TECLA, set counter=1, go to FILTRO.
  - FILTRO:
    - If TECLA_VALIDA=0, go to IDLE.
    - If TECLA differs from the latched code, relatch it and set counter=1.
    - Otherwise increment the counter. When the counter reaches DEBOUNCE_CYCLES, go to ACEPTAR.
  - ACEPTAR: one cycle; performs the key action; go to SOLTAR.
  - SOLTAR:
    - Count consecutive TECLA_VALIDA=0 cycles; any 1 resets the count.
    - After DEBOUNCE_CYCLES zeros, go to IDLE.
    - A held key never repeats.
- Latency: TECLA_VALIDA high with a stable code at cycle 0 produces the strobe registered high during cycle DEBOUNCE_CYCLES+1. All strobes last exactly one cycle.
- Key actions in ACEPTAR, MODO=0:
  - Digit 0-9: DIGITO <= code, DIGITO_STB <= 1.
  - ENTER, BORRAR: ignored, no strobe.
  - CANCELAR: CANCELAR_STB <= 1.
  - Invalid code: ERROR_ENTRADA <= 1.
- Key actions in ACEPTAR, MODO=1:
  - Digit with DIGITOS_ACUM < MAX_DIGITS: acum <= acum*10 + digit, computed as (acum<<3)+(acum<<1)+digit in 32 bits; DIGITOS_ACUM++.
  - Digit with DIGITOS_ACUM == MAX_DIGITS: rejected, accumulator unchanged, ERROR_ENTRADA <= 1.
  - Leading zeros count as digits.
  - ENTER with DIGITOS_ACUM > 0: MONTO <= acum, MONTO_STB <= 1, then clear acum and DIGITOS_ACUM.
  - ENTER with DIGITOS_ACUM == 0: ERROR_ENTRADA <= 1, no MONTO_STB.
  - BORRAR: clear acum and DIGITOS_ACUM, no strobe.
  - CANCELAR: clear the accumulator and pulse CANCELAR_STB.
  - Invalid code: ERROR_ENTRADA <= 1.
- MODO change (registered previous MODO differs from current): clear acum and DIGITOS_ACUM that cycle. The key FSM is not disturbed. If the change coincides with ACEPTAR, the clear happens first, then the key acts in the new mode.
- DIGITO and MONTO hold their last value between strobes.
- Reset asserted mid-press or mid-accumulation discards everything; no strobe is generated.

Decomposition:
- Shared package atm_pkg:
  - Key codes: TECLA_ENTER=4'hA, TECLA_BORRAR=4'hB, TECLA_CANCELAR=4'hC.
  - Key FSM state encoding, one-hot 4 bits: IDLE, FILTRO, ACEPTAR, SOLTAR.
  - MODO_PIN=0, MODO_MONTO=1.
- Sub-module: atm_key_debounce, holding the key FSM and counter. It outputs TECLA_OK (one-cycle pulse) and the latched code. The parent holds the mode logic, accumulator and outputs.

Test Plan (DEBOUNCE_CYCLES=4):
- MODO=0, clean press TECLA=7 held 10 cycles then released -> exactly one DIGITO_STB, DIGITO=7, 5 cycles after press start; no repeat while held.
- MODO=0, bounce 1,0,1,0 then stable 1 with TECLA=3 -> a single DIGITO_STB only after 4 stable cycles; a code change 3->5 during FILTRO -> DIGITO=5.
- MODO=1, keys 1,2,5,0,ENTER -> MONTO=1250, one MONTO_STB, DIGITOS_ACUM back to 0.
- MODO=1, ten 9s then ENTER -> 10th digit pulses ERROR_ENTRADA; MONTO=999999999.
- MODO=1, keys 4,BORRAR,6,ENTER -> MONTO=6; ENTER with no digits -> ERROR_ENTRADA, no MONTO_STB; keys 8,CANCELAR -> CANCELAR_STB, accumulator 0.
- MODO=1, keys 3,2, then MODO toggles to 0, then RESET pulsed during FILTRO -> accumulator cleared by the mode change; no strobes after reset; all outputs 0.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad front-end.
// Holds the special key codes, the one-hot key FSM state encoding, the
// mode constants and small arithmetic helpers used by the amount
// accumulator.
package atm_pkg;

  localparam logic [3:0] TECLA_ENTER    = 4'hA;
  localparam logic [3:0] TECLA_BORRAR   = 4'hB;
  localparam logic [3:0] TECLA_CANCELAR = 4'hC;

  localparam logic MODO_PIN   = 1'b0;
  localparam logic MODO_MONTO = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_FILTRO  = 4'b0010,
    ST_ACEPTAR = 4'b0100,
    ST_SOLTAR  = 4'b1000
  } key_st_e;

  function automatic logic es_digito(input logic [3:0] c);
    return (c <= 4'd9);
  endfunction

  // acum*10 + d without a multiplier; wraps in 32 bits
  function automatic logic [31:0] mul10_add(input logic [31:0] a, input logic [3:0] d);
    return (a << 3) + (a << 1) + {28'd0, d};
  endfunction

endpackage

// File: rtl/atm_key_debounce.sv
// Key debouncer / press FSM.
// Accepts a press once TECLA_VALIDA has been high with an unchanged code for
// DEBOUNCE_CYCLES consecutive cycles, then waits for DEBOUNCE_CYCLES
// consecutive low cycles before arming again, so a held key never repeats.
// Ports:
//   CLK, RESET     clock, async active-low reset
//   TECLA_VALIDA   raw key-down level (may bounce)
//   TECLA          raw key code
//   TECLA_OK       one-cycle pulse, high during the accept cycle
//   TECLA_COD      code latched for the accepted press
module atm_key_debounce
  import atm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TECLA_VALIDA,
  input  logic [3:0] TECLA,
  output logic       TECLA_OK,
  output logic [3:0] TECLA_COD
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  key_st_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       code_q;
  logic             ok_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      ok_q    <= 1'b0;
    end else begin
      ok_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (TECLA_VALIDA) begin
            code_q  <= TECLA;
            cnt_q   <= CNT_W'(1);
            state_q <= ST_FILTRO;
          end
        end
        ST_FILTRO: begin
          if (!TECLA_VALIDA) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (TECLA != code_q) begin
            code_q <= TECLA;
            cnt_q  <= CNT_W'(1);
          end else if (cnt_q == CNT_LAST) begin
            // counter reaches DEBOUNCE_CYCLES on this edge
            cnt_q   <= '0;
            ok_q    <= 1'b1;
            state_q <= ST_ACEPTAR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_ACEPTAR: begin
          cnt_q   <= '0;
          state_q <= ST_SOLTAR;
        end
        ST_SOLTAR: begin
          // count consecutive released cycles; any high restarts the count
          if (TECLA_VALIDA) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign TECLA_OK  = ok_q;
  assign TECLA_COD = code_q;

endmodule

// File: rtl/atm_keypad_entry.sv
// ATM keypad front-end.
// Debounced keys are forwarded as single digits in PIN mode, or accumulated
// into a decimal amount (committed with ENTER) in amount mode.
// Ports:
//   CLK, RESET        clock, async active-low reset
//   TECLA_VALIDA      raw key-down level
//   TECLA             raw key code (0-9, A=ENTER, B=BORRAR, C=CANCELAR)
//   MODO              0 = PIN entry, 1 = amount entry
//   DIGITO/_STB       accepted PIN digit and its one-cycle strobe
//   MONTO/_STB        committed amount and its one-cycle strobe
//   CANCELAR_STB      one-cycle pulse on accepted CANCELAR
//   ERROR_ENTRADA     one-cycle pulse on a rejected key
//   DIGITOS_ACUM      digits currently held in the accumulator
module atm_keypad_entry
  import atm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_DIGITS      = 9,
  parameter int CNT_W           = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TECLA_VALIDA,
  input  logic [3:0]  TECLA,
  input  logic        MODO,
  output logic [3:0]  DIGITO,
  output logic        DIGITO_STB,
  output logic [31:0] MONTO,
  output logic        MONTO_STB,
  output logic        CANCELAR_STB,
  output logic        ERROR_ENTRADA,
  output logic [3:0]  DIGITOS_ACUM
);

  logic       tecla_ok;
  logic [3:0] tecla_cod;

  atm_key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb (
    .CLK          (CLK),
    .RESET        (RESET),
    .TECLA_VALIDA (TECLA_VALIDA),
    .TECLA        (TECLA),
    .TECLA_OK     (tecla_ok),
    .TECLA_COD    (tecla_cod)
  );

  logic        modo_q;
  logic [31:0] acum_q,  acum_d;
  logic [3:0]  ndig_q,  ndig_d;
  logic [3:0]  dig_q,   dig_d;
  logic [31:0] monto_q, monto_d;
  logic        dstb_q,  dstb_d;
  logic        mstb_q,  mstb_d;
  logic        cstb_q,  cstb_d;
  logic        err_q,   err_d;

  always_comb begin
    // a mode change clears first; a coincident key then acts in the new mode
    acum_d  = (MODO != modo_q) ? '0 : acum_q;
    ndig_d  = (MODO != modo_q) ? '0 : ndig_q;
    dig_d   = dig_q;
    monto_d = monto_q;
    dstb_d  = 1'b0;
    mstb_d  = 1'b0;
    cstb_d  = 1'b0;
    err_d   = 1'b0;
    if (tecla_ok) begin
      if (MODO == MODO_PIN) begin
        if (es_digito(tecla_cod)) begin
          dig_d  = tecla_cod;
          dstb_d = 1'b1;
        end else if (tecla_cod == TECLA_CANCELAR) begin
          cstb_d = 1'b1;
        end else if (tecla_cod != TECLA_ENTER && tecla_cod != TECLA_BORRAR) begin
          err_d = 1'b1;
        end
      end else begin
        if (es_digito(tecla_cod)) begin
          if (ndig_d < 4'(MAX_DIGITS)) begin
            acum_d = mul10_add(acum_d, tecla_cod);
            ndig_d = ndig_d + 4'd1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          unique case (tecla_cod)
            TECLA_ENTER: begin
              if (ndig_d != 4'd0) begin
                monto_d = acum_d;
                mstb_d  = 1'b1;
                acum_d  = '0;
                ndig_d  = '0;
              end else begin
                err_d = 1'b1;
              end
            end
            TECLA_BORRAR: begin
              acum_d = '0;
              ndig_d = '0;
            end
            TECLA_CANCELAR: begin
              acum_d = '0;
              ndig_d = '0;
              cstb_d = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      modo_q  <= MODO_PIN;
      acum_q  <= '0;
      ndig_q  <= '0;
      dig_q   <= '0;
      monto_q <= '0;
      dstb_q  <= 1'b0;
      mstb_q  <= 1'b0;
      cstb_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      modo_q  <= MODO;
      acum_q  <= acum_d;
      ndig_q  <= ndig_d;
      dig_q   <= dig_d;
      monto_q <= monto_d;
      dstb_q  <= dstb_d;
      mstb_q  <= mstb_d;
      cstb_q  <= cstb_d;
      err_q   <= err_d;
    end
  end

  assign DIGITO        = dig_q;
  assign DIGITO_STB    = dstb_q;
  assign MONTO         = monto_q;
  assign MONTO_STB     = mstb_q;
  assign CANCELAR_STB  = cstb_q;
  assign ERROR_ENTRADA = err_q;
  assign DIGITOS_ACUM  = ndig_q;

endmodule
